// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, loader state type and the lane/skew index helper
// used by the systolic-array input matrix loader.
package systolic_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DIM    = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        FEED = 2'd2
    } load_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } lane_sel_t;

    // Row-major element index that lane r presents at skew step t; valid=0 outside the skew window.
    function automatic lane_sel_t lane_elem_idx(input int r, input int t, input int dim);
        lane_sel_t sel;
        int        col;
        col       = t - r;
        sel.valid = 1'b0;
        sel.idx   = '0;
        if (col >= 0 && col < dim) begin
            sel.valid = 1'b1;
            sel.idx   = 32'(r * dim + col);
        end
        return sel;
    endfunction

endpackage

// File: rtl/mat_bank_nxn.sv
// mat_bank_nxn: DIM*DIM x DATA_W register bank with one write port and DIM
// combinational read ports, one per array lane.
module mat_bank_nxn
    import systolic_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DIM    = DEFAULT_DIM,
    localparam int IDX_W  = $clog2(DIM * DIM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DIM*IDX_W-1:0]  ridx,
    output logic [DIM*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DIM*DIM];

    // Element storage: cleared by reset only, otherwise written one element per accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIM * DIM; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Each lane reads its own element independently.
    always_comb begin
        rdata = '0;
        for (int r = 0; r < DIM; r++) begin
            rdata[r*DATA_W +: DATA_W] = mem[ridx[r*IDX_W +: IDX_W]];
        end
    end

endmodule

// File: rtl/input_mat_loader.sv
// input_mat_loader: buffers a row-major DIMxDIM matrix from a valid/ready stream and
// feeds it into the systolic array row lanes, lane r delayed r cycles.
// Optional macro INPUT_MAT_DBUF_EN builds a two-bank ping-pong buffer; undefined gives one bank.
module input_mat_loader
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DIM    = DEFAULT_DIM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic                  feed_start,
    output logic                  mat_full,
    output logic                  feed_valid,
    output logic [DIM*DATA_W-1:0] feed_data,
    output logic                  feed_last,
    output logic                  busy
);

    localparam int IDX_W    = $clog2(DIM * DIM);
    localparam int T_W      = $clog2(2 * DIM - 1);
    localparam int LAST_IDX = DIM * DIM - 1;
    localparam int LAST_T   = 2 * DIM - 2;
`ifdef INPUT_MAT_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    load_state_t           bank_state      [NB];
    load_state_t           bank_state_next [NB];
    logic [IDX_W-1:0]      wcnt, wcnt_next;
    logic [T_W-1:0]        t, t_next;
    logic                  wb, wb_next, wb_other;
    logic                  fb, fb_next, fb_other;
    logic                  accept;
    logic                  beat_next;
    logic                  last_next;
    logic                  beat_bank;
    lane_sel_t             lane_sel [DIM];
    logic [DIM-1:0]        lane_ok;
    logic [DIM*IDX_W-1:0]  rd_idx;
    logic [DIM*DATA_W-1:0] bank_rd [NB];
    logic [DIM*DATA_W-1:0] feed_data_next;

    // With a single bank both pointers stay on bank 0; with two banks they alternate.
    assign wb_other = (NB > 1) ? ~wb : 1'b0;
    assign fb_other = (NB > 1) ? ~fb : 1'b0;

    // Loading is only possible into the bank the write pointer designates, and only while it is empty.
    assign in_ready = (bank_state[wb] == LOAD);

    // Per-bank state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                bank_state[b] <= LOAD;
            end
        end else begin
            bank_state <= bank_state_next;
        end
    end

    // Next-state logic: load side fills the write bank, feed side walks the oldest full bank through the skew window.
    always_comb begin
        bank_state_next = bank_state;
        wcnt_next       = wcnt;
        t_next          = t;
        wb_next         = wb;
        fb_next         = fb;
        accept          = 1'b0;
        beat_next       = 1'b0;
        beat_bank       = fb;
        last_next       = 1'b0;
        if (clear) begin
            for (int b = 0; b < NB; b++) begin
                bank_state_next[b] = LOAD;
            end
            wcnt_next = '0;
            t_next    = '0;
            wb_next   = 1'b0;
            fb_next   = 1'b0;
        end else begin
            if (in_valid && bank_state[wb] == LOAD) begin
                accept = 1'b1;
                if (wcnt == IDX_W'(LAST_IDX)) begin
                    wcnt_next           = '0;
                    bank_state_next[wb] = FULL;
                    wb_next             = wb_other;
                end else begin
                    wcnt_next = wcnt + 1'b1;
                end
            end
            case (bank_state[fb])
                FULL: begin
                    if (feed_start) begin
                        bank_state_next[fb] = FEED;
                        t_next              = '0;
                        beat_next           = 1'b1;
                    end
                end
                FEED: begin
                    if (t == T_W'(LAST_T)) begin
                        bank_state_next[fb] = LOAD;
                        fb_next             = fb_other;
                        t_next              = '0;
                        if (feed_start && bank_state[fb_other] == FULL) begin
                            bank_state_next[fb_other] = FEED;
                            beat_next                 = 1'b1;
                            beat_bank                 = fb_other;
                        end
                    end else begin
                        t_next    = t + 1'b1;
                        beat_next = 1'b1;
                    end
                end
                default: begin
                end
            endcase
            last_next = beat_next && (t_next == T_W'(LAST_T));
        end
    end

    // Write counter, skew counter and bank pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= '0;
            t    <= '0;
            wb   <= 1'b0;
            fb   <= 1'b0;
        end else begin
            wcnt <= wcnt_next;
            t    <= t_next;
            wb   <= wb_next;
            fb   <= fb_next;
        end
    end

    // Address each lane with the element it must present on the upcoming beat.
    always_comb begin
        rd_idx  = '0;
        lane_ok = '0;
        for (int r = 0; r < DIM; r++) begin
            lane_sel[r]              = lane_elem_idx(r, int'(t_next), DIM);
            rd_idx[r*IDX_W +: IDX_W] = IDX_W'(lane_sel[r].idx);
            lane_ok[r]               = lane_sel[r].valid;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        mat_bank_nxn #(
            .DATA_W (DATA_W),
            .DIM    (DIM)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (accept && (wb == 1'(b))),
            .widx  (wcnt),
            .wdata (in_data),
            .ridx  (rd_idx),
            .rdata (bank_rd[b])
        );
    end

    // Lanes outside the skew window, and idle cycles, present zero.
    always_comb begin
        feed_data_next = '0;
        for (int r = 0; r < DIM; r++) begin
            if (beat_next && lane_ok[r]) begin
                feed_data_next[r*DATA_W +: DATA_W] = bank_rd[beat_bank][r*DATA_W +: DATA_W];
            end
        end
    end

    // Registered feed beat so the array sees clean, glitch-free lane values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            feed_valid <= 1'b0;
            feed_last  <= 1'b0;
            feed_data  <= '0;
        end else begin
            feed_valid <= beat_next;
            feed_last  <= last_next;
            feed_data  <= feed_data_next;
        end
    end

    // Status flags summarised across all banks.
    always_comb begin
        mat_full = 1'b0;
        busy     = (wcnt != '0);
        for (int b = 0; b < NB; b++) begin
            if (bank_state[b] == FULL) begin
                mat_full = 1'b1;
            end
            if (bank_state[b] != LOAD) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_mat_loader.sv
// tb_input_mat_loader: directed, self-checking bench for input_mat_loader (DIM=8, DATA_W=8).
// Builds with or without INPUT_MAT_DBUF_EN; the ping-pong sequence runs only when it is defined.
module tb_input_mat_loader;

    localparam int DATA_W = 8;
    localparam int DIM    = 8;
    localparam int N      = DIM * DIM;
    localparam int BEATS  = 2 * DIM - 1;
`ifdef INPUT_MAT_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    typedef struct {
        int          beat;
        logic [63:0] exp_data;
        logic        exp_last;
    } beat_vec_t;

    logic                  clk;
    logic                  reset;
    logic                  clear;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  feed_start;
    logic                  mat_full;
    logic                  feed_valid;
    logic [DIM*DATA_W-1:0] feed_data;
    logic                  feed_last;
    logic                  busy;

    int          n_checks;
    int          n_fail;
    logic [7:0]  model [3][N];
    logic [63:0] cap_data [2*BEATS];
    logic        cap_last [2*BEATS];
    beat_vec_t   vecs [5];

    input_mat_loader #(
        .DATA_W (DATA_W),
        .DIM    (DIM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .feed_start (feed_start),
        .mat_full   (mat_full),
        .feed_valid (feed_valid),
        .feed_data  (feed_data),
        .feed_last  (feed_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int slot, input int t);
        logic [63:0] v = '0;
        for (int r = 0; r < DIM; r++) begin
            if (t - r >= 0 && t - r < DIM) begin
                v[r*DATA_W +: DATA_W] = model[slot][r*DIM + t - r];
            end
        end
        return v;
    endfunction

    // Stream count elements first, first+1, ... into the DUT, recording them in model[slot].
    task automatic apply_stimulus(input int slot, input int first, input int count, input bit bubbles,
                                  output int stalls);
        int idx = 0;
        int cyc = 0;
        stalls = 0;
        while (idx < count && cyc < 2000) begin
            in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = 8'(first + idx);
            if (in_valid && in_ready) begin
                model[slot][idx] = 8'(first + idx);
                idx++;
            end else if (in_valid) begin
                stalls++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < count) check_output("load_timeout", 64'(idx), 64'(count));
    endtask

    // Hold feed_start for 'hold' cycles and capture nbeats consecutive beats.
    task automatic feed_and_capture(input int nbeats, input int hold, input logic exp_mf0);
        feed_start = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            if (b >= hold - 1) feed_start = 1'b0;
            check_output($sformatf("feed_valid_beat%0d", b), 64'(feed_valid), 64'd1);
            if (b == 0) check_output("mat_full_first_beat", 64'(mat_full), 64'(exp_mf0));
            cap_data[b] = feed_data;
            cap_last[b] = feed_last;
        end
        feed_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic compare_beats(input int slot, input int offset);
        for (int t = 0; t < BEATS; t++) begin
            check_output($sformatf("beat_data_s%0d_t%0d", slot, t), cap_data[offset + t], exp_beat(slot, t));
            check_output($sformatf("beat_last_s%0d_t%0d", slot, t), 64'(cap_last[offset + t]),
                         64'(t == BEATS - 1));
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_output({tag, "_mat_full"}, 64'(mat_full), 64'd0);
        check_output({tag, "_feed_valid"}, 64'(feed_valid), 64'd0);
        check_output({tag, "_feed_last"}, 64'(feed_last), 64'd0);
        check_output({tag, "_feed_data"}, feed_data, 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int stalls;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        feed_start = 1'b0;

        // Hand-computed beats for matrix 1..64 (A[r][c] = 8r+c+1), lane 0 in the low byte.
        vecs[0] = '{0,  64'h00000000_00000001, 1'b0};
        vecs[1] = '{3,  64'h00000000_19120B04, 1'b0};
        vecs[2] = '{7,  64'h39322B24_1D160F08, 1'b0};
        vecs[3] = '{10, 64'h3C352E27_20000000, 1'b0};
        vecs[4] = '{14, 64'h40000000_00000000, 1'b1};

        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("idle");

        // feed_start while loading must be ignored
        feed_start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("start_in_load_valid", 64'(feed_valid), 64'd0);
        end
        feed_start = 1'b0;
        check_output("start_in_load_busy", 64'(busy), 64'd0);

        // Load 1..64 without bubbles and check the full handshake
        apply_stimulus(0, 1, N, 1'b0, stalls);
        check_output("load1_stalls", 64'(stalls), 64'd0);
        check_output("load1_mat_full", 64'(mat_full), 64'd1);
        check_output("load1_in_ready", 64'(in_ready), 64'(DBUF));
        check_output("load1_busy", 64'(busy), 64'd1);
`ifndef INPUT_MAT_DBUF_EN
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check_output("push_when_full_mat_full", 64'(mat_full), 64'd1);
`endif
        feed_and_capture(BEATS, 1, 1'b0);
        check_output("after_feed_valid", 64'(feed_valid), 64'd0);
        check_output("after_feed_in_ready", 64'(in_ready), 64'd1);
        check_output("after_feed_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("table_beat%0d_data", vecs[i].beat), cap_data[vecs[i].beat], vecs[i].exp_data);
            check_output($sformatf("table_beat%0d_last", vecs[i].beat), 64'(cap_last[vecs[i].beat]),
                         64'(vecs[i].exp_last));
        end
        compare_beats(0, 0);

        // Load with random bubbles, then feed
        apply_stimulus(1, 101, N, 1'b1, stalls);
        check_output("load2_mat_full", 64'(mat_full), 64'd1);
        feed_and_capture(BEATS, 1, 1'b0);
        compare_beats(1, 0);

        // clear after a partial load, then a fresh load
        apply_stimulus(0, 7, 30, 1'b0, stalls);
        check_output("partial_busy", 64'(busy), 64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle("clear_partial");
        apply_stimulus(0, 150, N, 1'b0, stalls);
        feed_and_capture(BEATS, 1, 1'b0);
        compare_beats(0, 0);

        // clear at feed beat 5
        apply_stimulus(0, 1, N, 1'b0, stalls);
        feed_start = 1'b1;
        @(negedge clk);
        feed_start = 1'b0;
        repeat (5) @(negedge clk);
        check_output("beat5_valid", 64'(feed_valid), 64'd1);
        check_output("beat5_data", feed_data, exp_beat(0, 5));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle("clear_feed");
        feed_start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_output("start_after_clear_valid", 64'(feed_valid), 64'd0);
        end
        feed_start = 1'b0;

        // Async reset in the middle of a feed
        apply_stimulus(0, 30, N, 1'b0, stalls);
        feed_start = 1'b1;
        @(negedge clk);
        feed_start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("pre_reset_valid", 64'(feed_valid), 64'd1);
        #2 reset = 1'b1;
        #1 check_idle("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef INPUT_MAT_DBUF_EN
        // Two matrices back to back, while a third loads into the freed bank
        apply_stimulus(0, 1, N, 1'b0, stalls);
        check_output("dbuf_a_stalls", 64'(stalls), 64'd0);
        check_output("dbuf_a_in_ready", 64'(in_ready), 64'd1);
        apply_stimulus(1, 65, N, 1'b0, stalls);
        check_output("dbuf_b_stalls", 64'(stalls), 64'd0);
        check_output("dbuf_both_full_in_ready", 64'(in_ready), 64'd0);
        check_output("dbuf_both_full_mat_full", 64'(mat_full), 64'd1);
        fork
            feed_and_capture(2 * BEATS, BEATS + 1, 1'b1);
            apply_stimulus(2, 129, N, 1'b0, stalls);
        join
        check_output("dbuf_c_stalls", 64'(stalls), 64'd16);
        compare_beats(0, 0);
        compare_beats(1, BEATS);
        check_output("dbuf_c_mat_full", 64'(mat_full), 64'd1);
        feed_and_capture(BEATS, 1, 1'b0);
        compare_beats(2, 0);
        check_output("dbuf_end_in_ready", 64'(in_ready), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
